target_placer: RTL

TARGET_PLACER -- requirements
Module: target_placer

---
 rtl/target_placer.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/target_placer.sv
// Target placer: draws random candidate cells, checks each against the snake-body store,
// and falls back to a raster sweep of the playfield when random draws keep colliding.
module target_placer #(
  parameter int GRID_W    = 320,
  parameter int GRID_H    = 240,
  parameter int MAX_RETRY = 8,
  localparam int CW       = $clog2(MAX_RETRY) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          target_ate_i,
  input  logic [17:0]   rnd_addr_i,
  output logic          gen_req_o,
  output logic          occ_req_o,
  output logic [8:0]    occ_x_o,
  output logic [8:0]    occ_y_o,
  input  logic          occ_ack_i,
  input  logic          occ_hit_i,
  output logic [8:0]    target_x_o,
  output logic [8:0]    target_y_o,
  output logic          target_valid_o,
  output logic          placed_o,
  output logic          grid_full_o,
  output logic          busy_o,
  output logic [CW-1:0] retry_cnt_o
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    QUERY,
    RETRY,
    SWEEP,
    DONE
  } state_e;

  localparam logic [CW-1:0] RETRY_LAST = CW'(MAX_RETRY - 1);
  localparam logic [9:0]    W_LIM      = 10'(GRID_W);
  localparam logic [9:0]    H_LIM      = 10'(GRID_H);
  localparam logic [8:0]    X_LAST     = 9'(GRID_W - 1);
  localparam logic [8:0]    Y_LAST     = 9'(GRID_H - 1);

  state_e        state_q, state_d;
  logic [8:0]    cand_x_q, cand_x_d;
  logic [8:0]    cand_y_q, cand_y_d;
  logic [8:0]    ptr_x_q, ptr_x_d;
  logic [8:0]    ptr_y_q, ptr_y_d;
  logic [CW-1:0] retry_q, retry_d;
  logic [8:0]    tgt_x_q, tgt_x_d;
  logic [8:0]    tgt_y_q, tgt_y_d;
  logic          tgt_valid_q, tgt_valid_d;
  logic          full_q, full_d;

  logic [8:0]    rnd_x;
  logic [8:0]    rnd_y;
  logic          cand_oob;
  logic          retry_more;
  logic          ptr_last;

  assign rnd_x      = rnd_addr_i[8:0];
  assign rnd_y      = rnd_addr_i[17:9];
  assign cand_oob   = ({1'b0, cand_x_q} >= W_LIM) || ({1'b0, cand_y_q} >= H_LIM);
  assign retry_more = retry_q < RETRY_LAST;
  assign ptr_last   = (ptr_x_q == X_LAST) && (ptr_y_q == Y_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cand_x_q    <= '0;
      cand_y_q    <= '0;
      ptr_x_q     <= '0;
      ptr_y_q     <= '0;
      retry_q     <= '0;
      tgt_x_q     <= '0;
      tgt_y_q     <= '0;
      tgt_valid_q <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_x_q    <= cand_x_d;
      cand_y_q    <= cand_y_d;
      ptr_x_q     <= ptr_x_d;
      ptr_y_q     <= ptr_y_d;
      retry_q     <= retry_d;
      tgt_x_q     <= tgt_x_d;
      tgt_y_q     <= tgt_y_d;
      tgt_valid_q <= tgt_valid_d;
      full_q      <= full_d;
    end
  end

  // The target registers load on the way into DONE so target_valid rises together with placed.
  always_comb begin
    state_d     = state_q;
    cand_x_d    = cand_x_q;
    cand_y_d    = cand_y_q;
    ptr_x_d     = ptr_x_q;
    ptr_y_d     = ptr_y_q;
    retry_d     = retry_q;
    tgt_x_d     = tgt_x_q;
    tgt_y_d     = tgt_y_q;
    tgt_valid_d = tgt_valid_q;
    full_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (target_ate_i) begin
          cand_x_d    = rnd_x;
          cand_y_d    = rnd_y;
          tgt_valid_d = 1'b0;
          retry_d     = '0;
          state_d     = CHECK;
        end
      end
      CHECK: begin
        state_d = cand_oob ? RETRY : QUERY;
      end
      QUERY: begin
        if (occ_ack_i) begin
          if (occ_hit_i) begin
            state_d = RETRY;
          end else begin
            tgt_x_d     = cand_x_q;
            tgt_y_d     = cand_y_q;
            tgt_valid_d = 1'b1;
            state_d     = DONE;
          end
        end
      end
      RETRY: begin
        if (retry_more) begin
          cand_x_d = rnd_x;
          cand_y_d = rnd_y;
          retry_d  = retry_q + CW'(1);
          state_d  = CHECK;
        end else begin
          ptr_x_d = '0;
          ptr_y_d = '0;
          state_d = SWEEP;
        end
      end
      SWEEP: begin
        if (occ_ack_i) begin
          if (!occ_hit_i) begin
            cand_x_d    = ptr_x_q;
            cand_y_d    = ptr_y_q;
            tgt_x_d     = ptr_x_q;
            tgt_y_d     = ptr_y_q;
            tgt_valid_d = 1'b1;
            state_d     = DONE;
          end else if (ptr_last) begin
            full_d  = 1'b1;
            state_d = IDLE;
          end else if (ptr_x_q == X_LAST) begin
            ptr_x_d = '0;
            ptr_y_d = ptr_y_q + 9'd1;
          end else begin
            ptr_x_d = ptr_x_q + 9'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    gen_req_o = 1'b0;
    occ_req_o = 1'b0;
    occ_x_o   = cand_x_q;
    occ_y_o   = cand_y_q;
    placed_o  = 1'b0;
    busy_o    = 1'b1;

    case (state_q)
      IDLE: begin
        gen_req_o = target_ate_i && !rst_i;
        busy_o    = 1'b0;
      end
      QUERY: begin
        occ_req_o = 1'b1;
      end
      RETRY: begin
        gen_req_o = retry_more && !rst_i;
      end
      SWEEP: begin
        occ_req_o = 1'b1;
        occ_x_o   = ptr_x_q;
        occ_y_o   = ptr_y_q;
      end
      DONE: begin
        placed_o = 1'b1;
      end
      default: begin
        busy_o = 1'b1;
      end
    endcase
  end

  assign target_x_o     = tgt_x_q;
  assign target_y_o     = tgt_y_q;
  assign target_valid_o = tgt_valid_q;
  assign grid_full_o    = full_q;
  assign retry_cnt_o    = retry_q;

endmodule
